// File: rtl/dg0045_pkg.sv
// Shared types and constants for the DG0045 core and its program-memory front end.
package dg0045_pkg;

  localparam int unsigned PC_W   = 10;
  localparam int unsigned HALF_W = 5;
  localparam int unsigned ROM_W  = 8;

  // Opcode the core decodes as a no-operation.
  localparam logic [ROM_W-1:0] NOP_OPCODE = 8'h00;

  typedef enum logic [2:0] {
    StSelLo,
    StSelHi,
    StSelLo2,
    StCheck,
    StWait
  } fetch_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dg0045_rom_fetch.sv
// Scans the multiplexed PC_HL bus, rebuilds the 10-bit PC and fetches the addressed byte
// from a req/ack program memory, holding it for the core.
module dg0045_rom_fetch
  import dg0045_pkg::*;
#(
  parameter int unsigned       SETTLE_CYC = 2,
  parameter int unsigned       TIMEOUT    = 15,
  parameter logic [ROM_W-1:0]  NOP_BYTE   = NOP_OPCODE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [HALF_W-1:0] i_pc_hl,
  output logic              o_pc_mux,
  output logic              o_mem_req,
  output logic [PC_W-1:0]   o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [ROM_W-1:0]  i_mem_rdata,
  output logic [ROM_W-1:0]  o_rom_data,
  output logic              o_rom_valid,
  output logic              o_fetch_err
);

  localparam int unsigned CntMax = max_u(SETTLE_CYC, TIMEOUT);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] SettleLd  = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLd = CntW'(TIMEOUT - 1);

  fetch_state_e      r_state;
  logic [CntW-1:0]   r_cnt;
  logic [HALF_W-1:0] r_lo1;
  logic [HALF_W-1:0] r_hi;
  logic [HALF_W-1:0] r_lo2;
  logic [PC_W-1:0]   r_last_addr;
  logic              r_have_addr;
  logic              r_pc_mux;
  logic              r_mem_req;
  logic [PC_W-1:0]   r_mem_addr;
  logic [ROM_W-1:0]  r_rom_data;
  logic              r_rom_valid;
  logic              r_fetch_err;

  logic [PC_W-1:0]   w_addr;
  logic              w_cnt_zero;

  assign w_addr     = {r_hi, r_lo2};
  assign w_cnt_zero = (r_cnt == '0);

  // One down-counter times both the bus settle window and the memory timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StSelLo;
      r_cnt       <= '0;
      r_lo1       <= '0;
      r_hi        <= '0;
      r_lo2       <= '0;
      r_last_addr <= '0;
      r_have_addr <= 1'b0;
      r_pc_mux    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_rom_data  <= NOP_BYTE;
      r_rom_valid <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      case (r_state)
        StSelLo: begin
          if (w_cnt_zero) begin
            r_lo1    <= i_pc_hl;
            r_pc_mux <= 1'b1;
            r_cnt    <= SettleLd;
            r_state  <= StSelHi;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StSelHi: begin
          if (w_cnt_zero) begin
            r_hi     <= i_pc_hl;
            r_pc_mux <= 1'b0;
            r_cnt    <= SettleLd;
            r_state  <= StSelLo2;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StSelLo2: begin
          if (w_cnt_zero) begin
            r_lo2   <= i_pc_hl;
            r_state <= StCheck;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StCheck: begin
          // A low half that moved mid-scan means hi may belong to either PC; rescan.
          if (r_lo1 != r_lo2) begin
            r_cnt   <= SettleLd;
            r_state <= StSelLo;
          end else if (r_have_addr && (w_addr == r_last_addr)) begin
            r_rom_valid <= 1'b1;
            r_cnt       <= SettleLd;
            r_state     <= StSelLo;
          end else begin
            r_rom_valid <= 1'b0;
            r_mem_addr  <= w_addr;
            r_mem_req   <= 1'b1;
            r_cnt       <= TimeoutLd;
            r_state     <= StWait;
          end
        end
        StWait: begin
          if (i_mem_ack) begin
            r_rom_data  <= i_mem_rdata;
            r_last_addr <= r_mem_addr;
            r_have_addr <= 1'b1;
            r_rom_valid <= 1'b1;
            r_mem_req   <= 1'b0;
            r_cnt       <= SettleLd;
            r_state     <= StSelLo;
          end else if (w_cnt_zero) begin
            r_rom_data  <= NOP_BYTE;
            r_rom_valid <= 1'b0;
            r_fetch_err <= 1'b1;
            r_have_addr <= 1'b0;
            r_mem_req   <= 1'b0;
            r_cnt       <= SettleLd;
            r_state     <= StSelLo;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        default: begin
          r_cnt   <= SettleLd;
          r_state <= StSelLo;
        end
      endcase
    end
  end

  assign o_pc_mux    = r_pc_mux;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_rom_data  = r_rom_data;
  assign o_rom_valid = r_rom_valid;
  assign o_fetch_err = r_fetch_err;

endmodule

// File: tb/tb_dg0045_rom_fetch.sv
// Directed bench: PC_HL bus model, req/ack memory responder and hand-computed expectations.
module tb_dg0045_rom_fetch;

  logic       clk;
  logic       rst;
  logic [4:0] pc_hl;
  logic       pc_mux;
  logic       mem_req;
  logic [9:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] rom_data;
  logic       rom_valid;
  logic       fetch_err;

  logic [9:0] pc;
  bit         ack_en;
  int         ack_delay;
  int         late_cnt;

  int         n_checks;
  int         n_errors;

  int         req_cnt;
  int         rom_chg;
  logic [9:0] last_req_addr;

  dg0045_rom_fetch #(
    .SETTLE_CYC (2),
    .TIMEOUT    (15),
    .NOP_BYTE   (8'h00)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pc_hl     (pc_hl),
    .o_pc_mux    (pc_mux),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata),
    .o_rom_data  (rom_data),
    .o_rom_valid (rom_valid),
    .o_fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core side: PC_HL shows PL[4:0] or {PU,PL[5]} depending on the select.
  assign pc_hl = pc_mux ? pc[9:5] : pc[4:0];

  function automatic logic [7:0] mem_model(input logic [9:0] a);
    return a[7:0] ^ 8'hA5 ^ {6'b0, a[9:8]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks ack_delay negedges into a request, plus on-demand stray pulses.
  initial begin : responder
    int age;
    int late_seen;
    age       = 0;
    late_seen = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req) age++;
      else age = 0;
      mem_ack   = 1'b0;
      mem_rdata = mem_model(mem_addr);
      if (ack_en && mem_req && (age == ack_delay)) mem_ack = 1'b1;
      if (late_cnt != late_seen) begin
        late_seen = late_cnt;
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
      end
    end
  end

  initial begin : monitor
    logic       prev_req;
    logic [7:0] prev_rom;
    req_cnt       = 0;
    rom_chg       = 0;
    last_req_addr = '0;
    prev_req      = 1'b0;
    prev_rom      = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        req_cnt++;
        last_req_addr = mem_addr;
      end
      if (rom_data !== prev_rom) rom_chg++;
      prev_req = mem_req;
      prev_rom = rom_data;
    end
  end

  task automatic wait_fetch(input string tag, input int budget);
    int  prev;
    bit  ok;
    prev = req_cnt;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((req_cnt > prev) && rom_valid && !mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int prev;
    bit ok;
    prev = req_cnt;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_cnt > prev) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_mux(input logic level, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pc_mux == level) break;
    end
  endtask

  initial begin : main
    int p_req;
    int p_chg;
    int hi_cyc;
    bit ok;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    pc        = 10'h000;
    ack_en    = 1'b1;
    ack_delay = 2;
    late_cnt  = 0;

    repeat (3) @(negedge clk);
    check("rst_pc_mux", 32'(pc_mux), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h000);
    check("rst_rom_data", 32'(rom_data), 32'h00);
    check("rst_rom_valid", 32'(rom_valid), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);

    // 1: first fetch of PC 0x000 within 3*2+1+3 clocks
    rst = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rom_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("t1_valid_in_time", 32'(ok), 32'd1);
    check("t1_rom_data", 32'(rom_data), 32'hA5);
    check("t1_mem_addr", 32'(mem_addr), 32'h000);
    check("t1_req_count", 32'(req_cnt), 32'd1);

    // 2: PC steps 0x005 then 0x3E1
    pc = 10'h005;
    wait_fetch("t2a_fetch", 40);
    check("t2a_rom_data", 32'(rom_data), 32'hA0);
    check("t2a_addr", 32'(last_req_addr), 32'h005);
    pc    = 10'h3E1;
    p_req = req_cnt;
    p_chg = rom_chg;
    ok    = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    check("t2b_req_seen", 32'(ok), 32'd1);
    check("t2b_valid_drop", 32'(rom_valid), 32'd0);
    check("t2b_req_addr", 32'(mem_addr), 32'h3E1);
    check("t2b_rom_held", 32'(rom_data), 32'hA0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rom_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("t2b_valid_back", 32'(ok), 32'd1);
    check("t2b_rom_data", 32'(rom_data), 32'h47);
    check("t2b_one_req", 32'(req_cnt - p_req), 32'd1);
    check("t2b_one_rom_change", 32'(rom_chg - p_chg), 32'd1);

    // 3: hold PC 0x2A6 for 100 clocks
    p_req = req_cnt;
    p_chg = rom_chg;
    pc    = 10'h2A6;
    repeat (100) @(negedge clk);
    check("t3_one_req", 32'(req_cnt - p_req), 32'd1);
    check("t3_one_rom_change", 32'(rom_chg - p_chg), 32'd1);
    check("t3_req_addr", 32'(last_req_addr), 32'h2A6);
    check("t3_rom_data", 32'(rom_data), 32'h01);
    check("t3_valid", 32'(rom_valid), 32'd1);

    // 4: PL[4:0] moves after lo1 capture; the torn scan must not fetch
    wait_mux(1'b0, 20);
    wait_mux(1'b1, 20);
    pc    = 10'h2B9;
    p_req = req_cnt;
    repeat (5) @(negedge clk);
    check("t4_no_torn_req", 32'(req_cnt - p_req), 32'd0);
    check("t4_valid_kept", 32'(rom_valid), 32'd1);
    wait_fetch("t4_fetch", 20);
    check("t4_req_addr", 32'(last_req_addr), 32'h2B9);
    check("t4_rom_data", 32'(rom_data), 32'h1E);

    // 5: no ack -> timeout after 15 clocks, then a retry that succeeds
    ack_en = 1'b0;
    pc     = 10'h155;
    wait_req("t5_req_seen", 40);
    hi_cyc = 0;
    while (mem_req && (hi_cyc < 40)) begin
      hi_cyc++;
      @(negedge clk);
    end
    check("t5_req_cycles", 32'(hi_cyc), 32'd15);
    check("t5_rom_nop", 32'(rom_data), 32'h00);
    check("t5_valid", 32'(rom_valid), 32'd0);
    check("t5_err", 32'(fetch_err), 32'd1);
    ack_en = 1'b1;
    wait_fetch("t5_retry_fetch", 20);
    check("t5_retry_addr", 32'(last_req_addr), 32'h155);
    check("t5_retry_rom", 32'(rom_data), 32'hF1);
    check("t5_err_sticky", 32'(fetch_err), 32'd1);

    // 6: reset in WAIT, then a stray ack
    ack_en = 1'b0;
    pc     = 10'h0F0;
    wait_req("t6_req_seen", 40);
    rst = 1'b1;
    @(negedge clk);
    check("t6_req_drop", 32'(mem_req), 32'd0);
    check("t6_pc_mux", 32'(pc_mux), 32'd0);
    check("t6_addr", 32'(mem_addr), 32'h000);
    check("t6_err_clear", 32'(fetch_err), 32'd0);
    rst = 1'b0;
    late_cnt++;
    repeat (2) @(negedge clk);
    check("t6_rom_nop", 32'(rom_data), 32'h00);
    check("t6_valid", 32'(rom_valid), 32'd0);
    check("t6_req", 32'(mem_req), 32'd0);
    check("t6_err", 32'(fetch_err), 32'd0);
    ack_en = 1'b1;
    wait_fetch("t6_fetch", 30);
    check("t6_rom_data", 32'(rom_data), 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
